capacity_timeout: RTL and testbench

//  Capacity aggregator for burst/credit issue. Accumulates request amounts into a

---
 rtl/capacity_timeout_pkg.sv | 13 +
 rtl/capacity_timeout.sv | 103 ++++++++++
 tb/tb_capacity_timeout.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/capacity_timeout_pkg.sv
// rtl/capacity_timeout_pkg.sv - shared types for the capacity aggregator
// Purpose: issue-decision encoding used by capacity_timeout.
// Ports: none (package).
package capacity_timeout_pkg;

  // What the output register loads on a given cycle.
  typedef enum logic [1:0] {
    ISSUE_NONE  = 2'd0,  // nothing to issue, valid drops
    ISSUE_FULL  = 2'd1,  // a full MAX-sized issue
    ISSUE_FLUSH = 2'd2   // timed-out partial remainder
  } issue_kind_e;

endpackage

// File: rtl/capacity_timeout.sv
// rtl/capacity_timeout.sv - capacity aggregator with timeout flush
// Purpose: accumulates request amounts into a queued-capacity counter and emits
//   issue commands of up to max_issue_size+ISSUE_SIZE_OFFSET units; a partial
//   remainder is flushed once it has waited `timeout` cycles.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   cke                 clock enable, 0 freezes all state
//   max_issue_size      max issue size, offset-encoded
//   timeout             flush wait in cycles
//   queued_request      units accumulated but not yet issued
//   current_timer       wait timer for the partial remainder
//   s_request_size/valid  request amount (offset-encoded) and strobe, no backpressure
//   m_issue_size/valid/ready  issue command stream, offset-encoded size
module capacity_timeout
  import capacity_timeout_pkg::*;
#(
  parameter int                        TIMER_WIDTH         = 8,
  parameter int                        CAPACITY_WIDTH      = 32,
  parameter int                        REQUEST_WIDTH       = CAPACITY_WIDTH,
  parameter int                        ISSUE_WIDTH         = 8,
  parameter logic                      REQUEST_SIZE_OFFSET = 1'b0,
  parameter logic                      ISSUE_SIZE_OFFSET   = 1'b1,
  parameter logic [CAPACITY_WIDTH-1:0] INIT_REQUEST        = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cke,
  input  logic [ISSUE_WIDTH-1:0]    max_issue_size,
  input  logic [TIMER_WIDTH-1:0]    timeout,
  output logic [CAPACITY_WIDTH-1:0] queued_request,
  output logic [TIMER_WIDTH-1:0]    current_timer,
  input  logic [REQUEST_WIDTH-1:0]  s_request_size,
  input  logic                      s_request_valid,
  output logic [ISSUE_WIDTH-1:0]    m_issue_size,
  output logic                      m_issue_valid,
  input  logic                      m_issue_ready
);

  logic [ISSUE_WIDTH:0]      max_units;    // one extra bit so max+offset never wraps
  logic [CAPACITY_WIDTH-1:0] req_units;
  logic [CAPACITY_WIDTH-1:0] issue_units;
  logic [CAPACITY_WIDTH-1:0] queued_next;
  logic                      load;
  issue_kind_e               kind;

  always_comb begin
    max_units = {1'b0, max_issue_size} + {{ISSUE_WIDTH{1'b0}}, ISSUE_SIZE_OFFSET};

    req_units = '0;
    if (s_request_valid) begin
      req_units = CAPACITY_WIDTH'(s_request_size) + CAPACITY_WIDTH'(REQUEST_SIZE_OFFSET);
    end

    // Output register may only change when empty or being consumed.
    load = cke && (!m_issue_valid || m_issue_ready);

    kind = ISSUE_NONE;
    if (load) begin
      if ((max_units != '0) && (queued_request >= CAPACITY_WIDTH'(max_units))) begin
        kind = ISSUE_FULL;
      end else if ((queued_request != '0) && (current_timer >= timeout)) begin
        kind = ISSUE_FLUSH;
      end
    end

    case (kind)
      ISSUE_FULL:  issue_units = CAPACITY_WIDTH'(max_units);
      ISSUE_FLUSH: issue_units = queued_request;
      default:     issue_units = '0;
    endcase

    // Same-cycle request and deduction combine; overflow wraps by design.
    queued_next = queued_request + req_units - issue_units;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      queued_request <= INIT_REQUEST;
      current_timer  <= '0;
      m_issue_size   <= '0;
      m_issue_valid  <= 1'b0;
    end else if (cke) begin
      queued_request <= queued_next;

      // Timer measures how long a nonzero remainder has waited since the last issue.
      if ((kind != ISSUE_NONE) || (queued_request == '0)) begin
        current_timer <= '0;
      end else if (current_timer != '1) begin
        current_timer <= current_timer + TIMER_WIDTH'(1);
      end

      if (load) begin
        m_issue_valid <= (kind != ISSUE_NONE);
        if (kind == ISSUE_FULL) begin
          m_issue_size <= max_issue_size;
        end else if (kind == ISSUE_FLUSH) begin
          m_issue_size <= ISSUE_WIDTH'(queued_request - CAPACITY_WIDTH'(ISSUE_SIZE_OFFSET));
        end
      end
    end
  end

endmodule

// File: tb/tb_capacity_timeout.sv
// tb/tb_capacity_timeout.sv - directed self-checking bench for capacity_timeout
module tb_capacity_timeout;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [7:0]  max_issue_size;
  logic [7:0]  timeout;
  logic [31:0] queued_request;
  logic [7:0]  current_timer;
  logic [31:0] s_request_size;
  logic        s_request_valid;
  logic [7:0]  m_issue_size;
  logic        m_issue_valid;
  logic        m_issue_ready;

  int checks = 0;
  int errors = 0;

  capacity_timeout dut (
    .clk             (clk),
    .reset           (reset),
    .cke             (cke),
    .max_issue_size  (max_issue_size),
    .timeout         (timeout),
    .queued_request  (queued_request),
    .current_timer   (current_timer),
    .s_request_size  (s_request_size),
    .s_request_valid (s_request_valid),
    .m_issue_size    (m_issue_size),
    .m_issue_valid   (m_issue_valid),
    .m_issue_ready   (m_issue_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] size);
    s_request_size  = size;
    s_request_valid = 1'b1;
    tick();
    s_request_valid = 1'b0;
    s_request_size  = '0;
  endtask

  // Ticks until m_issue_valid rises; returns ticks taken and last timer seen before it.
  task automatic wait_issue(input int bound, output int n, output logic [7:0] last_t);
    n = 0;
    last_t = current_timer;
    while (!m_issue_valid && n < bound) begin
      last_t = current_timer;
      tick();
      n++;
    end
  endtask

  initial begin
    int          n;
    logic [7:0]  lt;
    longint      req_sum;
    longint      iss_sum;
    int          drained;

    reset = 1'b1; cke = 1'b1;
    max_issue_size = 8'h7f; timeout = 8'h0f;
    s_request_size = '0; s_request_valid = 1'b0; m_issue_ready = 1'b1;
    repeat (3) tick();

    // 1 reset state
    check("rst_queued", queued_request, 0);
    check("rst_timer", current_timer, 0);
    check("rst_valid", m_issue_valid, 0);
    check("rst_size", m_issue_size, 0);
    reset = 1'b0;
    tick();

    // 2 single small request flushes after the timeout
    request(9);
    check("t2_queued", queued_request, 9);
    check("t2_timer0", current_timer, 0);
    wait_issue(40, n, lt);
    check("t2_latency", n, 16);
    check("t2_last_timer", lt, 15);
    check("t2_size", m_issue_size, 8);
    check("t2_queued_after", queued_request, 0);
    tick();
    check("t2_valid_drop", m_issue_valid, 0);

    // 3 back-to-back 200 + 100
    s_request_valid = 1'b1; s_request_size = 200;
    tick();
    check("t3_q200", queued_request, 200);
    s_request_size = 100;
    tick();
    s_request_valid = 1'b0;
    check("t3_v1", m_issue_valid, 1);
    check("t3_s1", m_issue_size, 8'h7f);
    check("t3_q1", queued_request, 172);
    tick();
    check("t3_v2", m_issue_valid, 1);
    check("t3_s2", m_issue_size, 8'h7f);
    check("t3_q2", queued_request, 44);
    tick();
    check("t3_gap", m_issue_valid, 0);
    wait_issue(40, n, lt);
    check("t3_flush_seen", m_issue_valid, 1);
    check("t3_s3", m_issue_size, 43);
    check("t3_q3", queued_request, 0);
    tick();

    // 4 backpressure holds the issue while requests accumulate
    request(130);
    m_issue_ready = 1'b0;
    tick();
    check("t4_v", m_issue_valid, 1);
    check("t4_s", m_issue_size, 8'h7f);
    check("t4_q", queued_request, 2);
    request(5);
    check("t4_held_v", m_issue_valid, 1);
    check("t4_q_acc", queued_request, 7);
    repeat (20) tick();
    check("t4_hold_v", m_issue_valid, 1);
    check("t4_hold_s", m_issue_size, 8'h7f);
    check("t4_hold_q", queued_request, 7);
    m_issue_ready = 1'b1;
    tick();
    check("t4_flush_v", m_issue_valid, 1);
    check("t4_flush_s", m_issue_size, 6);
    check("t4_flush_q", queued_request, 0);
    tick();
    check("t4_idle", m_issue_valid, 0);

    // 5 timeout=0 flushes one cycle after queued becomes nonzero
    timeout = 8'h00;
    request(5);
    check("t5_q", queued_request, 5);
    check("t5_v0", m_issue_valid, 0);
    tick();
    check("t5_v1", m_issue_valid, 1);
    check("t5_s", m_issue_size, 4);
    check("t5_q0", queued_request, 0);
    tick();
    timeout = 8'h0f;

    // cke=0 freezes queued and timer
    request(9);
    cke = 1'b0;
    repeat (30) tick();
    check("cke_q", queued_request, 9);
    check("cke_t", current_timer, 0);
    check("cke_v", m_issue_valid, 0);
    cke = 1'b1;
    wait_issue(40, n, lt);
    check("cke_resume_s", m_issue_size, 8);
    tick();

    // reset mid-operation discards a pending issue
    m_issue_ready = 1'b0;
    request(200);
    tick();
    check("mid_v", m_issue_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_v", m_issue_valid, 0);
    check("mid_rst_q", queued_request, 0);
    tick();
    reset = 1'b0;
    m_issue_ready = 1'b1;
    tick();

    // 6 random traffic then drain; units in must equal units out
    req_sum = 0; iss_sum = 0;
    for (int i = 0; i < 2000; i++) begin
      m_issue_ready   = ($urandom_range(0, 1) == 1);
      s_request_valid = ($urandom_range(0, 9) == 0);
      s_request_size  = $urandom_range(0, 255);
      if (s_request_valid) req_sum += s_request_size;
      if (m_issue_valid && m_issue_ready) iss_sum += m_issue_size + 1;
      tick();
    end
    s_request_valid = 1'b0;
    m_issue_ready   = 1'b1;
    drained = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m_issue_valid && queued_request == 0) begin
        drained = 1;
        break;
      end
      if (m_issue_valid) iss_sum += m_issue_size + 1;
      tick();
    end
    check("rand_drained", drained, 1);
    check("rand_sum", iss_sum[31:0], req_sum[31:0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
